// File: rtl/el2_lsu_trigger_seq.sv
// el2_lsu_trigger_seq
// LSU M-stage trigger unit: NUM_TRIG address / store-data comparators with
// even/odd pair chaining, per-channel hit-count thresholds and sticky hit
// status. Fires are registered into the R stage (one cycle after M).
// Build option: define TRIGGER_RANGE_EN to build the unsigned >= / <
// comparators used by modes 2 and 3. Without it those modes never match;
// mode 0 (equality / NAPOT mask) is identical in both builds.
// Counter rules per counting channel, in priority order:
//   cfg_wr            -> load trig_count, the same-cycle hit is dropped
//   hit, cnt == 0     -> fire on every hit
//   hit, cnt == 1     -> fire and reload trig_count (periodic)
//   hit, cnt >  1     -> decrement, no fire
module el2_lsu_trigger_seq #(
    parameter int NUM_TRIG = 4,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int CW       = 8
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic [NUM_TRIG-1:0]    trig_m,
    input  logic [NUM_TRIG-1:0]    trig_select,
    input  logic [NUM_TRIG-1:0]    trig_load,
    input  logic [NUM_TRIG-1:0]    trig_store,
    input  logic [NUM_TRIG-1:0]    trig_match,
    input  logic [2*NUM_TRIG-1:0]  trig_mode,
    input  logic [NUM_TRIG-1:0]    trig_chain,
    input  logic [32*NUM_TRIG-1:0] trig_tdata2,
    input  logic [CW*NUM_TRIG-1:0] trig_count,
    input  logic [NUM_TRIG-1:0]    cfg_wr,
    input  logic [NUM_TRIG-1:0]    sticky_clr,
    input  logic                   lsu_valid_m,
    input  logic                   lsu_load_m,
    input  logic                   lsu_store_m,
    input  logic                   lsu_dma_m,
    input  logic                   lsu_half_m,
    input  logic                   lsu_word_m,
    input  logic [AW-1:0]          lsu_addr_m,
    input  logic [DW-1:0]          store_data_m,
    input  logic                   flush_m,
    output logic [NUM_TRIG-1:0]    lsu_trigger_match_r,
    output logic [NUM_TRIG-1:0]    trig_hit_sticky
);

    logic                        trig_en;
    logic [31:0]                 addr_word;
    logic [31:0]                 store_word;
    logic [31:0]                 store_masked;
    logic [NUM_TRIG-1:0][31:0]   operand;
    logic [NUM_TRIG-1:0][31:0]   tdata;
    logic [NUM_TRIG-1:0]         cmp_hit;
    logic [NUM_TRIG-1:0]         raw;
    logic [NUM_TRIG-1:0]         hit;
    logic [NUM_TRIG-1:0]         counting;
    logic [NUM_TRIG-1:0]         fire;
    logic [NUM_TRIG-1:0][CW-1:0] cnt_q;
    logic [NUM_TRIG-1:0][CW-1:0] cnt_d;
    logic                        unused_chain_odd;

    // Equality with optional NAPOT mask: bit j is ignored when the mask is
    // enabled and every tdata2 bit below j is one; bit 0 is always ignored
    // when the mask is enabled.
    function automatic logic mask_match(input logic [31:0] op,
                                        input logic [31:0] td,
                                        input logic        msk);
        logic ones_below;
        logic ok;
        ok         = 1'b1;
        ones_below = msk;
        for (int j = 0; j < 32; j++) begin
            if ((op[j] != td[j]) && !ones_below) begin
                ok = 1'b0;
            end
            ones_below = ones_below & td[j];
        end
        return ok;
    endfunction

    // Any armed channel powers the comparators; otherwise operands sit at 0.
    assign trig_en    = |trig_m;
    assign addr_word  = 32'(lsu_addr_m);
    assign store_word = 32'(store_data_m);

    // Size-mask the store data so byte/half stores compare only live bytes.
    always_comb begin
        store_masked = store_word;
        if (lsu_word_m) begin
            store_masked = store_word;
        end else if (lsu_half_m) begin
            store_masked = {16'h0000, store_word[15:0]};
        end else begin
            store_masked = {24'h000000, store_word[7:0]};
        end
    end

    // Odd chain bits carry no meaning; fold them so they are consumed.
    always_comb begin
        unused_chain_odd = 1'b0;
        for (int i = 1; i < NUM_TRIG; i += 2) begin
            unused_chain_odd = unused_chain_odd ^ trig_chain[i];
        end
    end

    // Per-channel operand select, compare and qualification into raw hits.
    always_comb begin
        operand = '0;
        tdata   = '0;
        cmp_hit = '0;
        raw     = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            tdata[i] = trig_tdata2[32*i +: 32];
            if (trig_en) begin
                if (!trig_select[i]) begin
                    operand[i] = addr_word;
                end else if (trig_store[i]) begin
                    operand[i] = store_masked;
                end
            end
            case (trig_mode[2*i +: 2])
                2'd0:    cmp_hit[i] = mask_match(operand[i], tdata[i], trig_match[i]);
`ifdef TRIGGER_RANGE_EN
                2'd2:    cmp_hit[i] = (operand[i] >= tdata[i]);
                2'd3:    cmp_hit[i] = (operand[i] <  tdata[i]);
`endif
                default: cmp_hit[i] = 1'b0;
            endcase
            raw[i] = lsu_valid_m & ~lsu_dma_m & trig_m[i] & ~flush_m &
                     ((trig_store[i] & lsu_store_m) |
                      (trig_load[i] & lsu_load_m & ~trig_select[i])) &
                     cmp_hit[i];
        end
    end

    // Chaining, threshold counters and fire generation. A chained odd
    // channel neither counts nor loads; it mirrors its even partner.
    always_comb begin
        hit      = raw;
        counting = '1;
        cnt_d    = cnt_q;
        fire     = '0;
        for (int i = 0; i < NUM_TRIG; i += 2) begin
            if (trig_chain[i]) begin
                hit[i]        = raw[i] & raw[i+1];
                hit[i+1]      = raw[i] & raw[i+1];
                counting[i+1] = 1'b0;
            end
        end
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (counting[i]) begin
                if (trig_en && cfg_wr[i]) begin
                    cnt_d[i] = trig_count[CW*i +: CW];
                end else if (hit[i]) begin
                    if (cnt_q[i] == '0) begin
                        fire[i] = 1'b1;
                    end else if (cnt_q[i] == CW'(1)) begin
                        fire[i]  = 1'b1;
                        cnt_d[i] = trig_count[CW*i +: CW];
                    end else begin
                        cnt_d[i] = cnt_q[i] - CW'(1);
                    end
                end
            end
        end
        for (int i = 0; i < NUM_TRIG; i += 2) begin
            if (trig_chain[i]) begin
                fire[i+1] = fire[i];
            end
        end
    end

    // R-stage fire register, sticky status (set beats clear) and counters.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lsu_trigger_match_r <= '0;
            trig_hit_sticky     <= '0;
            cnt_q               <= '0;
        end else begin
            lsu_trigger_match_r <= fire;
            trig_hit_sticky     <= (trig_hit_sticky & ~sticky_clr) | fire;
            cnt_q               <= cnt_d;
        end
    end

endmodule

// File: tb/tb_el2_lsu_trigger_seq.sv
// tb_el2_lsu_trigger_seq
// Directed vector table, a hand-written async-reset sequence and a
// randomized run checked against a behavioural model of the trigger rules.
module tb_el2_lsu_trigger_seq;

    localparam int NT = 4;
    localparam int CW = 8;

    localparam int OP_N  = 0;
    localparam int OP_LD = 1;
    localparam int OP_SB = 2;
    localparam int OP_SH = 3;
    localparam int OP_SW = 4;
    localparam int M_NO  = 0;
    localparam int M_FL  = 1;
    localparam int M_DMA = 2;
    localparam int M_INV = 3;

`ifdef TRIGGER_RANGE_EN
    localparam logic [3:0] RH = 4'b1000;
`else
    localparam logic [3:0] RH = 4'b0000;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic              clk;
    logic              rst_l;
    logic [NT-1:0]     trig_m, trig_select, trig_load, trig_store, trig_match, trig_chain;
    logic [2*NT-1:0]   trig_mode;
    logic [32*NT-1:0]  trig_tdata2;
    logic [CW*NT-1:0]  trig_count;
    logic [NT-1:0]     cfg_wr, sticky_clr;
    logic              lsu_valid_m, lsu_load_m, lsu_store_m, lsu_dma_m;
    logic              lsu_half_m, lsu_word_m, flush_m;
    logic [31:0]       lsu_addr_m, store_data_m;
    logic [NT-1:0]     lsu_trigger_match_r, trig_hit_sticky;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    el2_lsu_trigger_seq #(.NUM_TRIG(NT), .AW(32), .DW(32), .CW(CW)) dut (
        .clk                 (clk),
        .rst_l               (rst_l),
        .trig_m              (trig_m),
        .trig_select         (trig_select),
        .trig_load           (trig_load),
        .trig_store          (trig_store),
        .trig_match          (trig_match),
        .trig_mode           (trig_mode),
        .trig_chain          (trig_chain),
        .trig_tdata2         (trig_tdata2),
        .trig_count          (trig_count),
        .cfg_wr              (cfg_wr),
        .sticky_clr          (sticky_clr),
        .lsu_valid_m         (lsu_valid_m),
        .lsu_load_m          (lsu_load_m),
        .lsu_store_m         (lsu_store_m),
        .lsu_dma_m           (lsu_dma_m),
        .lsu_half_m          (lsu_half_m),
        .lsu_word_m          (lsu_word_m),
        .lsu_addr_m          (lsu_addr_m),
        .store_data_m        (store_data_m),
        .flush_m             (flush_m),
        .lsu_trigger_match_r (lsu_trigger_match_r),
        .trig_hit_sticky     (trig_hit_sticky)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // ---------------- configurations ----------------
    typedef struct {
        logic [3:0]   m, sel, ld, st, mt, chain;
        logic [7:0]   mode;
        logic [127:0] td;
        logic [31:0]  cnt;
    } cfg_t;

    cfg_t cfgs[7];

    task automatic set_ch(input int c, input int ch, input bit m, input bit sel, input bit ld,
                          input bit st, input bit mt, input logic [1:0] mode,
                          input logic [31:0] td, input logic [7:0] cnt);
        cfgs[c].m[ch]              = m;
        cfgs[c].sel[ch]            = sel;
        cfgs[c].ld[ch]             = ld;
        cfgs[c].st[ch]             = st;
        cfgs[c].mt[ch]             = mt;
        cfgs[c].mode[2*ch +: 2]    = mode;
        cfgs[c].td[32*ch +: 32]    = td;
        cfgs[c].cnt[8*ch +: 8]     = cnt;
    endtask

    task automatic apply_cfg(input int c);
        trig_m      = cfgs[c].m;
        trig_select = cfgs[c].sel;
        trig_load   = cfgs[c].ld;
        trig_store  = cfgs[c].st;
        trig_match  = cfgs[c].mt;
        trig_chain  = cfgs[c].chain;
        trig_mode   = cfgs[c].mode;
        trig_tdata2 = cfgs[c].td;
        trig_count  = cfgs[c].cnt;
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_op(input int op, input int md, input logic [31:0] a, input logic [31:0] d);
        lsu_valid_m  = (op != OP_N) && (md != M_INV);
        lsu_load_m   = (op == OP_LD);
        lsu_store_m  = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        lsu_half_m   = (op == OP_SH);
        lsu_word_m   = (op == OP_SW) || (op == OP_LD);
        flush_m      = (md == M_FL);
        lsu_dma_m    = (md == M_DMA);
        lsu_addr_m   = a;
        store_data_m = d;
    endtask

    task automatic drive_idle();
        cfg_wr     = '0;
        sticky_clr = '0;
        apply_op(OP_N, M_NO, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        @(posedge clk);
        #1;
        rst_l = 1'b0;
        #2;
        check("reset_match", lsu_trigger_match_r, 4'b0000);
        check("reset_sticky", trig_hit_sticky, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        step();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        int          cfg;
        logic [3:0]  wr;
        logic [3:0]  clr;
        int          op;
        int          md;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [3:0]  em;
        logic [3:0]  es;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit rst, input int cfg, input logic [3:0] wr, input logic [3:0] clr,
                           input int op, input int md, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [3:0] em, input logic [3:0] es);
        vec_t v;
        v.rst = rst; v.cfg = cfg; v.wr = wr; v.clr = clr; v.op = op; v.md = md;
        v.addr = addr; v.sdata = sdata; v.em = em; v.es = es;
        vecs.push_back(v);
    endtask

    // ---------------- behavioural reference model ----------------
    int         mcnt[NT];
    logic [3:0] msticky;

    function automatic logic [31:0] m_operand(input int c);
        if (trig_m == 4'b0000) return 32'h0;
        if (!trig_select[c]) return lsu_addr_m;
        if (!trig_store[c]) return 32'h0;
        if (lsu_word_m) return store_data_m;
        if (lsu_half_m) return store_data_m % 32'h1_0000;
        return store_data_m % 32'h100;
    endfunction

    function automatic bit m_compare(input int c, input logic [31:0] op);
        logic [63:0] td;
        logic [1:0]  mode;
        int          t;
        td   = {32'h0, trig_tdata2[32*c +: 32]};
        mode = trig_mode[2*c +: 2];
        if (mode == 2'd0) begin
            if (!trig_match[c]) return op == td[31:0];
            t = 0;
            while (t < 32 && td[t]) t++;
            return ({32'h0, op} >> (t + 1)) == (td >> (t + 1));
        end
`ifdef TRIGGER_RANGE_EN
        if (mode == 2'd2) return op >= td[31:0];
        if (mode == 2'd3) return op < td[31:0];
`endif
        return 1'b0;
    endfunction

    function automatic bit m_access(input int c);
        return lsu_valid_m && !lsu_dma_m && !flush_m && trig_m[c] &&
               ((trig_store[c] && lsu_store_m) ||
                (trig_load[c] && lsu_load_m && !trig_select[c]));
    endfunction

    function automatic bit m_count(input int c, input bit h);
        int reload;
        reload = int'(trig_count[8*c +: 8]);
        if (trig_m != 4'b0000 && cfg_wr[c]) begin
            mcnt[c] = reload;
            return 1'b0;
        end
        if (!h) return 1'b0;
        if (mcnt[c] == 0) return 1'b1;
        if (mcnt[c] == 1) begin
            mcnt[c] = reload;
            return 1'b1;
        end
        mcnt[c] = mcnt[c] - 1;
        return 1'b0;
    endfunction

    task automatic model_cycle(output logic [3:0] f);
        bit r[NT];
        f = 4'b0000;
        for (int c = 0; c < NT; c++) r[c] = m_access(c) && m_compare(c, m_operand(c));
        for (int p = 0; p < NT; p += 2) begin
            if (trig_chain[p]) begin
                f[p]   = m_count(p, r[p] && r[p+1]);
                f[p+1] = f[p];
            end else begin
                f[p]   = m_count(p, r[p]);
                f[p+1] = m_count(p + 1, r[p+1]);
            end
        end
        msticky = (msticky & ~sticky_clr) | f;
    endtask

    // ---------------- random stimulus helpers ----------------
    function automatic logic [31:0] pick_val(input int k);
        case (k)
            0: return 32'h0000_0100;
            1: return 32'h0000_2000;
            2: return 32'h8000_0010;
            3: return 32'h0000_00FF;
            4: return 32'hFFFF_FFFF;
            5: return 32'h0000_1FFF;
            6: return 32'h1234_5600;
            7: return 32'h0000_01FF;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_cfg();
        bit off;
        int md;
        off = ($urandom_range(0, 9) == 0);
        for (int c = 0; c < NT; c++) begin
            trig_m[c]      = off ? 1'b0 : ($urandom_range(0, 7) != 0);
            trig_select[c] = 1'($urandom_range(0, 1));
            trig_load[c]   = 1'($urandom_range(0, 1));
            trig_store[c]  = 1'($urandom_range(0, 1));
            trig_match[c]  = 1'($urandom_range(0, 1));
            trig_chain[c]  = ($urandom_range(0, 2) == 0);
            md = $urandom_range(0, 5);
            trig_mode[2*c +: 2]   = (md > 3) ? 2'd0 : 2'(md);
            trig_tdata2[32*c +: 32] = pick_val($urandom_range(0, 8));
            trig_count[8*c +: 8]  = 8'($urandom_range(0, 3));
        end
    endtask

    // ---------------- main test ----------------
    initial begin
        logic [3:0] f;
        logic [7:0] e;
        rst_l = 1'b1;
        drive_idle();
        for (int c = 0; c < 7; c++) cfgs[c] = '{default: '0};

        // cfg0: ch0 load addr eq, ch1 store-data NAPOT, ch2 load addr count=3
        set_ch(0, 0, 1, 0, 1, 0, 0, 2'd0, 32'h8000_0010, 8'd0);
        set_ch(0, 1, 1, 1, 0, 1, 1, 2'd0, 32'h0000_00FF, 8'd0);
        set_ch(0, 2, 1, 0, 1, 0, 0, 2'd0, 32'h4000_0000, 8'd3);
        cfgs[1] = cfgs[0];
        cfgs[1].m[2] = 1'b0;
        // cfg2/3: ch0 addr==0x100 (load/store), ch1 any load; cfg2 chained
        set_ch(2, 0, 1, 0, 1, 1, 0, 2'd0, 32'h0000_0100, 8'd2);
        set_ch(2, 1, 1, 0, 1, 0, 1, 2'd0, 32'hFFFF_FFFF, 8'd0);
        cfgs[3] = cfgs[2];
        cfgs[2].chain[0] = 1'b1;
        // cfg4/5/6: ch3 range modes 2 / 3 and reserved mode 1
        set_ch(4, 3, 1, 0, 1, 0, 0, 2'd2, 32'h0000_2000, 8'd0);
        set_ch(5, 3, 1, 0, 1, 0, 0, 2'd3, 32'h0000_2000, 8'd0);
        set_ch(6, 3, 1, 0, 1, 0, 0, 2'd1, 32'h0000_2000, 8'd0);

        add_vec(1, 0, 4'h0, 4'h0, OP_LD, M_NO,  32'h8000_0010, 32'h0, 4'b0001, 4'b0001);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_NO,  32'h8000_0014, 32'h0, 4'b0000, 4'b0001);
        add_vec(0, 0, 4'h0, 4'h0, OP_SB, M_NO,  32'h0, 32'h1234_5600, 4'b0010, 4'b0011);
        add_vec(0, 0, 4'h0, 4'h0, OP_SW, M_NO,  32'h0, 32'h1234_5600, 4'b0000, 4'b0011);
        add_vec(0, 0, 4'h0, 4'h0, OP_SH, M_NO,  32'h0, 32'h1234_5600, 4'b0000, 4'b0011);
        add_vec(0, 0, 4'h0, 4'h0, OP_SB, M_NO,  32'h0, 32'h0000_01FF, 4'b0010, 4'b0011);
        add_vec(0, 0, 4'h0, 4'h0, OP_SW, M_NO,  32'h0, 32'h0000_01FF, 4'b0010, 4'b0011);
        add_vec(0, 0, 4'h0, 4'h0, OP_SW, M_NO,  32'h0, 32'h0000_03FF, 4'b0000, 4'b0011);
        add_vec(0, 0, 4'h4, 4'h0, OP_N,  M_NO,  32'h0, 32'h0, 4'b0000, 4'b0011);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_NO,  32'h4000_0000, 32'h0, 4'b0000, 4'b0011);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_NO,  32'h4000_0000, 32'h0, 4'b0000, 4'b0011);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_NO,  32'h4000_0000, 32'h0, 4'b0100, 4'b0111);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_NO,  32'h4000_0000, 32'h0, 4'b0000, 4'b0111);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_NO,  32'h4000_0000, 32'h0, 4'b0000, 4'b0111);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_NO,  32'h4000_0000, 32'h0, 4'b0100, 4'b0111);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_NO,  32'h4000_0000, 32'h0, 4'b0000, 4'b0111);
        add_vec(0, 0, 4'h4, 4'h0, OP_LD, M_NO,  32'h4000_0000, 32'h0, 4'b0000, 4'b0111);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_NO,  32'h4000_0000, 32'h0, 4'b0000, 4'b0111);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_NO,  32'h4000_0000, 32'h0, 4'b0000, 4'b0111);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_NO,  32'h4000_0000, 32'h0, 4'b0100, 4'b0111);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_FL,  32'h4000_0000, 32'h0, 4'b0000, 4'b0111);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_DMA, 32'h4000_0000, 32'h0, 4'b0000, 4'b0111);
        add_vec(0, 1, 4'h0, 4'h0, OP_LD, M_NO,  32'h4000_0000, 32'h0, 4'b0000, 4'b0111);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_NO,  32'h4000_0000, 32'h0, 4'b0000, 4'b0111);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_NO,  32'h4000_0000, 32'h0, 4'b0000, 4'b0111);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_NO,  32'h4000_0000, 32'h0, 4'b0100, 4'b0111);
        add_vec(0, 0, 4'h0, 4'h1, OP_LD, M_NO,  32'h8000_0010, 32'h0, 4'b0001, 4'b0111);
        add_vec(0, 0, 4'h0, 4'h2, OP_N,  M_NO,  32'h0, 32'h0, 4'b0000, 4'b0101);
        add_vec(0, 0, 4'h0, 4'h5, OP_N,  M_NO,  32'h0, 32'h0, 4'b0000, 4'b0000);
        add_vec(0, 0, 4'h0, 4'h0, OP_LD, M_INV, 32'h8000_0010, 32'h0, 4'b0000, 4'b0000);
        add_vec(1, 2, 4'h0, 4'h0, OP_LD, M_NO,  32'h0000_0100, 32'h0, 4'b0011, 4'b0011);
        add_vec(0, 2, 4'h0, 4'h0, OP_SW, M_NO,  32'h0000_0100, 32'h0, 4'b0000, 4'b0011);
        add_vec(0, 2, 4'h0, 4'h0, OP_LD, M_NO,  32'h0000_0104, 32'h0, 4'b0000, 4'b0011);
        add_vec(0, 3, 4'h0, 4'h0, OP_LD, M_NO,  32'h0000_0104, 32'h0, 4'b0010, 4'b0011);
        add_vec(0, 2, 4'h1, 4'h0, OP_N,  M_NO,  32'h0, 32'h0, 4'b0000, 4'b0011);
        add_vec(0, 2, 4'h0, 4'h0, OP_LD, M_NO,  32'h0000_0100, 32'h0, 4'b0000, 4'b0011);
        add_vec(0, 2, 4'h0, 4'h0, OP_LD, M_NO,  32'h0000_0100, 32'h0, 4'b0011, 4'b0011);
        add_vec(1, 4, 4'h0, 4'h0, OP_LD, M_NO,  32'h0000_1FFF, 32'h0, 4'b0000, 4'b0000);
        add_vec(0, 4, 4'h0, 4'h0, OP_LD, M_NO,  32'h0000_2000, 32'h0, RH, RH);
        add_vec(0, 4, 4'h0, 4'h0, OP_LD, M_NO,  32'hFFFF_FFFF, 32'h0, RH, RH);
        add_vec(0, 5, 4'h0, 4'h0, OP_LD, M_NO,  32'h0000_1FFF, 32'h0, RH, RH);
        add_vec(0, 5, 4'h0, 4'h0, OP_LD, M_NO,  32'h0000_2000, 32'h0, 4'b0000, RH);
        add_vec(0, 6, 4'h0, 4'h0, OP_LD, M_NO,  32'h0000_2000, 32'h0, 4'b0000, RH);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            apply_cfg(vecs[i].cfg);
            cfg_wr     = vecs[i].wr;
            sticky_clr = vecs[i].clr;
            apply_op(vecs[i].op, vecs[i].md, vecs[i].addr, vecs[i].sdata);
            step();
            check($sformatf("vec%0d_match", i), lsu_trigger_match_r, vecs[i].em);
            check($sformatf("vec%0d_sticky", i), trig_hit_sticky, vecs[i].es);
        end

        // Async reset mid-operation: state clears without a clock edge,
        // the pending fire is lost and the counter restarts from zero.
        do_reset();
        apply_cfg(0);
        cfg_wr = 4'b0100;
        step();
        drive_idle();
        apply_op(OP_LD, M_NO, 32'h4000_0000, 32'h0);
        step();
        check("arst_pre_cnt", lsu_trigger_match_r, 4'b0000);
        apply_op(OP_LD, M_NO, 32'h8000_0010, 32'h0);
        step();
        check("arst_pre_fire", lsu_trigger_match_r, 4'b0001);
        #2;
        rst_l = 1'b0;
        #1;
        check("arst_match", lsu_trigger_match_r, 4'b0000);
        check("arst_sticky", trig_hit_sticky, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        drive_idle();
        step();
        check("arst_lost_fire", lsu_trigger_match_r, 4'b0000);
        apply_op(OP_LD, M_NO, 32'h4000_0000, 32'h0);
        step();
        check("arst_cnt_zero", lsu_trigger_match_r, 4'b0100);

        // Randomized run against the reference model.
        do_reset();
        for (int c = 0; c < NT; c++) mcnt[c] = 0;
        msticky = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            int op;
            int mr;
            int md;
            if (n % 25 == 0) rand_cfg();
            cfg_wr     = 4'($urandom) & 4'($urandom) & 4'($urandom);
            sticky_clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
            op = $urandom_range(0, 4);
            mr = $urandom_range(0, 11);
            md = (mr < 8) ? M_NO : (mr - 8);
            apply_op(op, md, pick_val($urandom_range(0, 8)), pick_val($urandom_range(0, 8)));
            model_cycle(f);
            exp_q.push_back({f, msticky});
            step();
            e = exp_q.pop_front();
            check($sformatf("rand%0d_match", n), lsu_trigger_match_r, e[7:4]);
            check($sformatf("rand%0d_sticky", n), trig_hit_sticky, e[3:0]);
        end

        drive_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
